multicast_fifo_fork: RTL and testbench

Buffered, parametrised fork: one input channel fans out to NumOutputs output channels, each with its own Depth-entry FIFO. Slow consumers stall only their own lane until that FIFO fills. A per-token destination mask makes it a multicast. It replaces the unbuffered fork wherever consumers drift relative to each other, and it sits between a producer and independently paced consumers in the LLPM dataflow fabric.

---
 rtl/multicast_fifo_fork.sv | 115 +++++++++++
 tb/tb_multicast_fifo_fork.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/multicast_fifo_fork.sv
// multicast_fifo_fork: one producer fans out to NumOutputs lanes, each with
// its own Depth-entry circular FIFO. A per-token destination mask selects
// which lanes receive each token. A token is accepted only when every
// selected lane has room, and it is then written to all of those lanes in
// the same cycle.
// Optional feature: define MULTICAST_FIFO_FORK_BYPASS_EN to let an empty
// lane present the incoming token combinationally, giving 0-cycle latency.
module multicast_fifo_fork #(
    parameter int Width      = 8,
    parameter int NumOutputs = 4,
    parameter int Depth      = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [Width-1:0]            din,
    input  logic [NumOutputs-1:0]       din_mask,
    input  logic                        din_valid,
    output logic                        din_bp,
    output logic [NumOutputs*Width-1:0] dout,
    output logic [NumOutputs-1:0]       dout_valid,
    input  logic [NumOutputs-1:0]       dout_bp
);
    localparam int CW = $clog2(Depth + 1);
    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CW-1:0] FullCount = CW'(Depth);
    localparam logic [PW-1:0] LastPtr   = PW'(Depth - 1);

    logic [Width-1:0]      r_mem    [NumOutputs][Depth];
    logic [PW-1:0]         r_rd_ptr [NumOutputs];
    logic [PW-1:0]         r_wr_ptr [NumOutputs];
    logic [CW-1:0]         r_count  [NumOutputs];

    logic [NumOutputs-1:0] w_full;
    logic [NumOutputs-1:0] w_stored;
    logic [NumOutputs-1:0] w_push;
    logic [NumOutputs-1:0] w_pop;
    logic                  w_blocked;
    logic                  w_accept;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + PW'(1);
    endfunction

    // Per-lane status from registered state only; a same-cycle pop never frees a slot.
    always_comb begin
        w_full   = '0;
        w_stored = '0;
        for (int i = 0; i < NumOutputs; i++) begin
            w_full[i]   = (r_count[i] == FullCount);
            w_stored[i] = (r_count[i] != '0);
        end
    end

    // Acceptance depends only on mask, fullness and reset, never on dout_bp.
    assign w_blocked = |(din_mask & w_full);
    assign din_bp    = w_blocked | reset;
    assign w_accept  = din_valid & ~din_bp;

`ifdef MULTICAST_FIFO_FORK_BYPASS_EN
    logic [NumOutputs-1:0] w_byp;
    logic [NumOutputs-1:0] w_byp_take;

    // Empty selected lanes show din directly; a token taken straight through skips the FIFO.
    always_comb begin
        w_byp      = ~w_stored & din_mask & {NumOutputs{din_valid & ~reset}};
        w_byp_take = w_byp & ~dout_bp & {NumOutputs{w_accept}};
        w_push     = din_mask & {NumOutputs{w_accept}} & ~w_byp_take;
        w_pop      = w_stored & ~dout_bp;
        dout_valid = (w_stored & {NumOutputs{~reset}}) | w_byp;
        dout       = '0;
        for (int i = 0; i < NumOutputs; i++) begin
            dout[i*Width +: Width] = w_byp[i] ? din : r_mem[i][r_rd_ptr[i]];
        end
    end
`else
    // Registered-only outputs: lane head is visible whenever the lane holds a token.
    always_comb begin
        w_push     = din_mask & {NumOutputs{w_accept}};
        w_pop      = w_stored & ~dout_bp;
        dout_valid = w_stored & {NumOutputs{~reset}};
        dout       = '0;
        for (int i = 0; i < NumOutputs; i++) begin
            dout[i*Width +: Width] = r_mem[i][r_rd_ptr[i]];
        end
    end
`endif

    // Pointer and occupancy update per lane; reset discards all stored tokens.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumOutputs; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NumOutputs; i++) begin
                if (w_push[i]) r_wr_ptr[i] <= ptr_inc(r_wr_ptr[i]);
                if (w_pop[i])  r_rd_ptr[i] <= ptr_inc(r_rd_ptr[i]);
                unique case ({w_push[i], w_pop[i]})
                    2'b10:   r_count[i] <= r_count[i] + CW'(1);
                    2'b01:   r_count[i] <= r_count[i] - CW'(1);
                    default: r_count[i] <= r_count[i];
                endcase
            end
        end
    end

    // Token storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumOutputs; i++) begin
            if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= din;
        end
    end
endmodule

// File: tb/tb_multicast_fifo_fork.sv
// Directed bench for multicast_fifo_fork in its default (registered) build.
// Two instances: Depth=2 for broadcast/skew/multicast/reset, Depth=3 for the
// full boundary and pointer wrap on a non-power-of-two depth.
module tb_multicast_fifo_fork;
    logic        clk;
    logic        rst;

    logic [7:0]  a_din,   b_din;
    logic [3:0]  a_mask,  b_mask;
    logic        a_valid, b_valid;
    logic        a_bp,    b_bp;
    logic [31:0] a_dout,  b_dout;
    logic [3:0]  a_dv,    b_dv;
    logic [3:0]  a_obp,   b_obp;

    int n_total = 0;
    int n_bad   = 0;

    multicast_fifo_fork #(.Width(8), .NumOutputs(4), .Depth(2)) u_dut_d2 (
        .clk(clk), .reset(rst), .din(a_din), .din_mask(a_mask), .din_valid(a_valid),
        .din_bp(a_bp), .dout(a_dout), .dout_valid(a_dv), .dout_bp(a_obp)
    );

    multicast_fifo_fork #(.Width(8), .NumOutputs(4), .Depth(3)) u_dut_d3 (
        .clk(clk), .reset(rst), .din(b_din), .din_mask(b_mask), .din_valid(b_valid),
        .din_bp(b_bp), .dout(b_dout), .dout_valid(b_dv), .dout_bp(b_obp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle on the chosen instance (other idles), check at negedge, step past posedge.
    task automatic cyc(input bit use_b, input logic v, input logic [7:0] d, input logic [3:0] m,
                       input logic [3:0] obp, input logic exp_bp, input logic [3:0] exp_v,
                       input logic [31:0] exp_d, input string tag);
        logic [31:0] lm;
        if (use_b) begin
            b_valid = v; b_din = d; b_mask = m; b_obp = obp;
            a_valid = 1'b0; a_mask = 4'h0; a_obp = 4'h0;
        end else begin
            a_valid = v; a_din = d; a_mask = m; a_obp = obp;
            b_valid = 1'b0; b_mask = 4'h0; b_obp = 4'h0;
        end
        for (int i = 0; i < 4; i++) lm[i*8 +: 8] = {8{exp_v[i]}};
        @(negedge clk);
        chk({tag, "_bp"},   use_b ? {31'd0, b_bp} : {31'd0, a_bp}, {31'd0, exp_bp});
        chk({tag, "_dv"},   use_b ? {28'd0, b_dv} : {28'd0, a_dv}, {28'd0, exp_v});
        chk({tag, "_dout"}, (use_b ? b_dout : a_dout) & lm, exp_d & lm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] tok;
        int         sent;
        logic       ebp;
        logic [3:0] ev;
        logic [31:0] ed;

        rst = 1'b1;
        a_din = 8'h00; a_mask = 4'h0; a_valid = 1'b0; a_obp = 4'h0;
        b_din = 8'h00; b_mask = 4'h0; b_valid = 1'b0; b_obp = 4'h0;
        repeat (2) @(posedge clk);
        #1;

        // reset state with a pending token on the input
        cyc(0, 1, 8'hAA, 4'hF, 4'h0, 1, 4'h0, 32'h0, "rst_a");
        cyc(1, 1, 8'hAA, 4'hF, 4'h0, 1, 4'h0, 32'h0, "rst_b");
        rst = 1'b0;
        cyc(0, 0, 8'h00, 4'hF, 4'h0, 0, 4'h0, 32'h0, "post_rst");

        // broadcast
        cyc(0, 1, 8'h11, 4'hF, 4'h0, 0, 4'h0, 32'h0,         "bc0");
        cyc(0, 1, 8'h22, 4'hF, 4'h0, 0, 4'hF, 32'h11111111,  "bc1");
        cyc(0, 1, 8'h33, 4'hF, 4'h0, 0, 4'hF, 32'h22222222,  "bc2");
        cyc(0, 0, 8'h00, 4'hF, 4'h0, 0, 4'hF, 32'h33333333,  "bc3");
        cyc(0, 0, 8'h00, 4'hF, 4'h0, 0, 4'h0, 32'h0,         "bc4");

        // skew stall on lane 2
        cyc(0, 1, 8'h11, 4'hF, 4'h4, 0, 4'h0, 32'h0,         "sk0");
        cyc(0, 1, 8'h22, 4'hF, 4'h4, 0, 4'hF, 32'h11111111,  "sk1");
        cyc(0, 1, 8'h33, 4'hF, 4'h4, 1, 4'hF, 32'h22112222,  "sk2");
        cyc(0, 1, 8'h33, 4'hF, 4'h4, 1, 4'h4, 32'h00110000,  "sk3");
        cyc(0, 1, 8'h33, 4'hF, 4'h0, 1, 4'h4, 32'h00110000,  "sk4");
        cyc(0, 1, 8'h33, 4'hF, 4'h0, 0, 4'h4, 32'h00220000,  "sk5");
        cyc(0, 0, 8'h00, 4'hF, 4'h0, 0, 4'hF, 32'h33333333,  "sk6");
        cyc(0, 0, 8'h00, 4'hF, 4'h0, 0, 4'h0, 32'h0,         "sk7");

        // multicast and empty mask
        cyc(0, 1, 8'hA0, 4'b0101, 4'h0, 0, 4'h0,    32'h0,        "mc0");
        cyc(0, 1, 8'hB0, 4'b1010, 4'h0, 0, 4'b0101, 32'h00A000A0, "mc1");
        cyc(0, 1, 8'hC0, 4'b0000, 4'h0, 0, 4'b1010, 32'hB000B000, "mc2");
        cyc(0, 0, 8'h00, 4'b0000, 4'h0, 0, 4'h0,    32'h0,        "mc3");

        // reset mid-operation with lane 1 full
        cyc(0, 1, 8'h51, 4'b0010, 4'b0010, 0, 4'h0,    32'h0,        "rm0");
        cyc(0, 1, 8'h52, 4'b0010, 4'b0010, 0, 4'b0010, 32'h00005100, "rm1");
        cyc(0, 1, 8'h52, 4'b0010, 4'b0010, 1, 4'b0010, 32'h00005100, "rm_full");
        rst = 1'b1;
        cyc(0, 1, 8'h53, 4'hF, 4'h0, 1, 4'h0, 32'h0, "rm_in_rst");
        rst = 1'b0;
        cyc(0, 0, 8'h00, 4'hF, 4'h0, 0, 4'h0, 32'h0, "rm_after0");
        cyc(0, 0, 8'h00, 4'hF, 4'h0, 0, 4'h0, 32'h0, "rm_after1");

        // Depth=3 full boundary, lane 0 blocked
        cyc(1, 1, 8'h01, 4'b0001, 4'b0001, 0, 4'h0,    32'h0,        "fb0");
        cyc(1, 1, 8'h02, 4'b0001, 4'b0001, 0, 4'b0001, 32'h00000001, "fb1");
        cyc(1, 1, 8'h03, 4'b0001, 4'b0001, 0, 4'b0001, 32'h00000001, "fb2");
        cyc(1, 1, 8'h04, 4'b0001, 4'b0001, 1, 4'b0001, 32'h00000001, "fb_full");
        cyc(1, 1, 8'h04, 4'b1110, 4'b0001, 0, 4'b0001, 32'h00000001, "fb_other");
        cyc(1, 0, 8'h00, 4'b1110, 4'b0001, 0, 4'hF,    32'h04040401, "fb_others");

        // release lane 0 and stream 10 more tokens through it, wrapping pointers
        q = '{8'h01, 8'h02, 8'h03};
        tok = 8'h10;
        sent = 0;
        for (int c = 0; c < 30 && (sent < 10 || q.size() != 0); c++) begin
            ebp = (q.size() == 3);
            ev  = {3'b000, q.size() != 0};
            ed  = (q.size() != 0) ? {24'h0, q[0]} : 32'h0;
            if (sent < 10) cyc(1, 1, tok,   4'b0001, 4'h0, ebp, ev, ed, "wrap");
            else           cyc(1, 0, 8'h00, 4'b0001, 4'h0, ebp, ev, ed, "drain");
            if (q.size() != 0) void'(q.pop_front());
            if (sent < 10 && !ebp) begin
                q.push_back(tok);
                tok  = tok + 8'h01;
                sent++;
            end
        end
        cyc(1, 0, 8'h00, 4'b0001, 4'h0, 0, 4'h0, 32'h0, "wrap_end");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
